// File: rtl/hpi_access_sequencer.sv
// Avalon-MM slave that sequences one CY7C67200 HPI bus cycle per processor access,
// stalling the master with waitrequest until the cycle and its recovery gap finish.
module hpi_access_sequencer #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RECOVER} state_t;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RECOVER_LD = (RECOVERY_CYCLES == 0) ? 4'd0 : 4'(RECOVERY_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_load;
  logic        op_wr;
  logic [1:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] rd_q;
  logic        req;

  logic        cs_n_nxt, r_n_nxt, w_n_nxt, oe_nxt;
  logic [1:0]  addr_nxt;
  logic [15:0] dout_nxt;
  logic        cur_wr;
  logic [1:0]  cur_addr;
  logic [15:0] cur_data;

  logic unused_writedata;
  assign unused_writedata = ^writedata[31:16];

  assign req         = chipselect & (read | write);
  assign waitrequest = req & (state != DONE);
  assign readdata    = {16'b0, rd_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      op_wr           <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      rd_q            <= '0;
      otg_hpi_cs_n    <= 1'b1;
      otg_hpi_r_n     <= 1'b1;
      otg_hpi_w_n     <= 1'b1;
      otg_data_oe     <= 1'b0;
      otg_hpi_address <= '0;
      otg_data_out    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= cnt_load;
      else if (cnt != '0)     cnt <= cnt - 4'd1;
      if (state == IDLE && req) begin
        op_wr  <= write;
        addr_q <= address;
        data_q <= writedata[15:0];
      end
      if (state == STROBE && cnt == '0 && !op_wr) rd_q <= otg_data_in;
      otg_hpi_cs_n    <= cs_n_nxt;
      otg_hpi_r_n     <= r_n_nxt;
      otg_hpi_w_n     <= w_n_nxt;
      otg_data_oe     <= oe_nxt;
      otg_hpi_address <= addr_nxt;
      otg_data_out    <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = '0;
    case (state)
      IDLE:    if (req) state_nxt = SETUP;
      SETUP:   if (cnt == '0) state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
      RECOVER: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      SETUP:   cnt_load = SETUP_LD;
      STROBE:  cnt_load = STROBE_LD;
      HOLD:    cnt_load = HOLD_LD;
      RECOVER: cnt_load = RECOVER_LD;
      default: cnt_load = '0;
    endcase
  end

  // Pin values are derived from the next state so they switch on the entry edge;
  // on the IDLE->SETUP edge the latches are not yet loaded, so take the bus inputs.
  always_comb begin
    cur_wr   = (state == IDLE) ? write           : op_wr;
    cur_addr = (state == IDLE) ? address         : addr_q;
    cur_data = (state == IDLE) ? writedata[15:0] : data_q;
    cs_n_nxt = 1'b1;
    r_n_nxt  = 1'b1;
    w_n_nxt  = 1'b1;
    oe_nxt   = 1'b0;
    addr_nxt = otg_hpi_address;
    dout_nxt = otg_data_out;
    case (state_nxt)
      SETUP: begin
        cs_n_nxt = 1'b0;
        addr_nxt = cur_addr;
        oe_nxt   = cur_wr;
        if (cur_wr) dout_nxt = cur_data;
      end
      STROBE: begin
        cs_n_nxt = 1'b0;
        oe_nxt   = op_wr;
        r_n_nxt  = op_wr;
        w_n_nxt  = !op_wr;
      end
      HOLD: begin
        cs_n_nxt = 1'b0;
        oe_nxt   = op_wr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Randomized self-checking bench for hpi_access_sequencer: a default-timing instance and a
// minimum-timing instance are driven with transactions and compared against a cycle-position model.
module tb_hpi_access_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs_s [2];
  logic        rd_s [2];
  logic        wr_s [2];
  logic [1:0]  a_s  [2];
  logic [31:0] wd_s [2];
  logic [15:0] din_s[2];
  logic [31:0] rdata[2];
  logic        wreq [2];
  logic [1:0]  ha   [2];
  logic        hcs  [2];
  logic        hr   [2];
  logic        hw   [2];
  logic        oe   [2];
  logic [15:0] dout [2];

  localparam int SC [2] = '{2, 1};
  localparam int PC [2] = '{4, 1};
  localparam int HC [2] = '{2, 1};
  localparam int RC [2] = '{2, 0};

  hpi_access_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .address(a_s[0]), .chipselect(cs_s[0]),
    .read(rd_s[0]), .write(wr_s[0]), .writedata(wd_s[0]), .readdata(rdata[0]),
    .waitrequest(wreq[0]), .otg_hpi_address(ha[0]), .otg_hpi_cs_n(hcs[0]),
    .otg_hpi_r_n(hr[0]), .otg_hpi_w_n(hw[0]), .otg_data_out(dout[0]),
    .otg_data_oe(oe[0]), .otg_data_in(din_s[0])
  );

  hpi_access_sequencer #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .RECOVERY_CYCLES(0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(a_s[1]), .chipselect(cs_s[1]),
    .read(rd_s[1]), .write(wr_s[1]), .writedata(wd_s[1]), .readdata(rdata[1]),
    .waitrequest(wreq[1]), .otg_hpi_address(ha[1]), .otg_hpi_cs_n(hcs[1]),
    .otg_hpi_r_n(hr[1]), .otg_hpi_w_n(hw[1]), .otg_data_out(dout[1]),
    .otg_data_oe(oe[1]), .otg_data_in(din_s[1])
  );

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [15:0] din;
    bit          drop;
    bit          b2b;
    int          gap;
  } txn_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] rd_model [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic cs, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
    cs_s[d] = cs;
    rd_s[d] = rd;
    wr_s[d] = wr;
    a_s[d]  = a;
    wd_s[d] = wd;
  endtask

  task automatic check_pins(input int d, input int k, input string what,
                            input logic ecs, input logic er, input logic ew, input logic eoe);
    check($sformatf("d%0d k%0d %s pins{cs_n,r_n,w_n,oe}", d, k, what),
          {28'b0, hcs[d], hr[d], hw[d], oe[d]}, {28'b0, ecs, er, ew, eoe});
  endtask

  task automatic idle_cycle(input int d, input int k, input string what, input bit keep_req, input txn_t n);
    @(posedge clk); #1;
    if (keep_req) drive(d, n.cs, n.rd, n.wr, n.addr, n.wdata);
    else drive(d, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
    din_s[d] = 16'($urandom);
    #1;
    check_pins(d, k, what, 1'b1, 1'b1, 1'b1, 1'b0);
    check($sformatf("d%0d k%0d %s waitrequest", d, k, what), {31'b0, wreq[d]}, {31'b0, keep_req});
    check($sformatf("d%0d k%0d %s readdata", d, k, what), rdata[d], {16'b0, rd_model[d]});
  endtask

  task automatic run_txn(input int d, input txn_t t, input txn_t n, input bit have_next);
    int s, p, h, r, done;
    bit is_wr, req_now, active, strobe, nb;
    logic [15:0] rd_new, exp_rd;
    s = SC[d]; p = PC[d]; h = HC[d]; r = RC[d];
    done   = s + p + h + 1;
    is_wr  = t.wr;
    rd_new = is_wr ? rd_model[d] : t.din;
    for (int k = 0; k <= done; k++) begin
      @(posedge clk); #1;
      req_now = (k == 0) || !t.drop;
      if (req_now) drive(d, t.cs, t.rd, t.wr, t.addr, t.wdata);
      else drive(d, 1'b0, 1'b0, 1'b0, t.addr, t.wdata);
      din_s[d] = (k > s && k <= s + p) ? t.din : ~t.din;
      #1;
      active = (k >= 1) && (k <= s + p + h);
      strobe = (k > s) && (k <= s + p);
      check_pins(d, k, "txn", !active, !(strobe && !is_wr), !(strobe && is_wr), active && is_wr);
      check($sformatf("d%0d k%0d waitrequest", d, k), {31'b0, wreq[d]},
            {31'b0, req_now && (k != done)});
      if (active)
        check($sformatf("d%0d k%0d hpi_address", d, k), {30'b0, ha[d]}, {30'b0, t.addr});
      if (active && is_wr)
        check($sformatf("d%0d k%0d data_out", d, k), {16'b0, dout[d]}, {16'b0, t.wdata[15:0]});
      exp_rd = (k > s + p) ? rd_new : rd_model[d];
      check($sformatf("d%0d k%0d readdata", d, k), rdata[d], {16'b0, exp_rd});
    end
    rd_model[d] = rd_new;
    nb = have_next && t.b2b;
    for (int k = done + 1; k <= done + r; k++) idle_cycle(d, k, "recover", nb, n);
    if (!nb)
      for (int g = 0; g < t.gap; g++) idle_cycle(d, done + r + 1 + g, "gap", 1'b0, n);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int op;
    op      = int'($urandom_range(0, 2));
    t.cs    = 1'b1;
    t.rd    = (op != 1);
    t.wr    = (op != 0);
    t.addr  = 2'($urandom);
    t.wdata = $urandom;
    t.din   = 16'($urandom);
    t.drop  = ($urandom_range(0, 7) == 0);
    t.b2b   = 1'($urandom_range(0, 1));
    t.gap   = int'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic txn_t mk(input logic rd, input logic wr, input logic [1:0] a,
                              input logic [31:0] wd, input logic [15:0] din, input bit b2b);
    txn_t t;
    t.cs = 1'b1; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.din = din;
    t.drop = 1'b0; t.b2b = b2b; t.gap = 2;
    return t;
  endfunction

  initial begin
    txn_t t1, t2, t3, tr;
    txn_t list [$];
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      din_s[d] = '0;
      rd_model[d] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      check_pins(d, 0, "reset", 1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("d%0d reset hpi_address", d), {30'b0, ha[d]}, 32'd0);
      check($sformatf("d%0d reset data_out", d), {16'b0, dout[d]}, 32'd0);
      check($sformatf("d%0d reset readdata", d), rdata[d], 32'd0);
      check($sformatf("d%0d reset waitrequest", d), {31'b0, wreq[d]}, 32'd0);
    end
    @(negedge clk) reset_n = 1'b1;

    // Directed: write, back-to-back read, then read+write treated as write.
    t1 = mk(1'b0, 1'b1, 2'd2, 32'h0000_5A3C, 16'h0000, 1'b1);
    t2 = mk(1'b1, 1'b0, 2'd0, 32'h0000_0000, 16'hBEEF, 1'b1);
    t3 = mk(1'b1, 1'b1, 2'd1, 32'h0000_0001, 16'h7777, 1'b0);
    run_txn(0, t1, t2, 1'b1);
    run_txn(0, t2, t3, 1'b1);
    run_txn(0, t3, t3, 1'b0);
    check("d0 readdata after rd+wr", rdata[0], 32'h0000_BEEF);

    // Asynchronous reset in the middle of a write strobe.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0000_A5A5);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
    end
    check_pins(0, 4, "pre-reset", 1'b0, 1'b1, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_pins(0, 4, "async reset", 1'b1, 1'b1, 1'b1, 1'b0);
    check("d0 async reset data_out", {16'b0, dout[0]}, 32'd0);
    check("d0 async reset readdata", rdata[0], 32'd0);
    rd_model[0] = '0;
    rd_model[1] = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 6; k++) idle_cycle(0, k, "post-reset", 1'b0, t1);

    for (int d = 0; d < 2; d++) begin
      list.delete();
      for (int i = 0; i < 16; i++) list.push_back(rand_txn());
      for (int i = 0; i < 16; i++) begin
        tr = (i + 1 < 16) ? list[i + 1] : list[i];
        run_txn(d, list[i], tr, (i + 1 < 16));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpi_access_sequencer.md
Name: hpi_access_sequencer

Overview:
- Avalon-MM slave that turns one processor read/write into a correctly timed HPI bus cycle to the EZ-OTG (CY7C67200) host-port interface.
- Replaces direct software bit-banging of the separate HPI address/data/rd/wr/cs PIOs.
- Sits between the Nios II data master and the OTG chip pins.
- Stalls the master with waitrequest until the bus cycle and its recovery interval complete.

Parameters:
- SETUP_CYCLES, 2: clocks with address/cs_n (and write data) valid before strobe; legal range 1..15.
- STROBE_CYCLES, 4: clocks r_n or w_n held low; legal range 1..15.
- HOLD_CYCLES, 2: clocks address/cs_n/data held after strobe release; legal range 1..15.
- RECOVERY_CYCLES, 2: clocks cs_n high before the next access may start; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  HPI register select (0 data, 1 mailbox, 2 address, 3 status).
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  32  write data; bits [15:0] used.
- readdata  out  32  {16'b0, captured HPI data}.
- waitrequest  out  1  Avalon stall.
- otg_hpi_address  out  2  HPI A[1:0] pins.
- otg_hpi_cs_n  out  1  HPI chip select, active low.
- otg_hpi_r_n  out  1  HPI read strobe, active low.
- otg_hpi_w_n  out  1  HPI write strobe, active low.
- otg_data_out  out  16  data driven to the HPI bus.
- otg_data_oe  out  1  tri-state enable for otg_data_out; the top level owns the bidirectional pad.
- otg_data_in  in  16  data sampled from the HPI bus.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state IDLE; cs_n, r_n, w_n = 1; otg_hpi_address = 0; otg_data_out = 0; otg_data_oe = 0; readdata = 0.
  - Any in-flight bus cycle is abandoned; it is not completed after reset releases.
- All pin outputs and readdata are registered.
- waitrequest is combinational: chipselect & (read | write) & (state != DONE).
- Request precedence: read and write both asserted is treated as a write.
- State machine; one 4-bit down-counter is loaded on every state entry:
  - IDLE:
    - Request sampled → latch address, op and writedata[15:0]; go to SETUP.
    - No request → stay.
  - SETUP (SETUP_CYCLES clocks):
    - cs_n = 0, otg_hpi_address = latched address.
    - Write: otg_data_oe = 1, otg_data_out = latched data. Read: otg_data_oe = 0.
  - STROBE (STROBE_CYCLES clocks):
    - r_n = 0 (read) or w_n = 0 (write); address, cs_n and data unchanged.
    - Read: otg_data_in is captured into readdata on the final STROBE clock edge.
  - HOLD (HOLD_CYCLES clocks): r_n = w_n = 1; cs_n, address, data and oe unchanged.
  - DONE (exactly 1 clock):
    - cs_n = 1, otg_data_oe = 0; waitrequest = 0, so the master completes this cycle.
    - readdata is valid.
    - Next state is RECOVER, or IDLE if RECOVERY_CYCLES = 0.
  - RECOVER (RECOVERY_CYCLES clocks): cs_n = 1; requests present are stalled; then IDLE.
- Latency with default parameters, cycle 0 = request sampled in IDLE:
  - SETUP 1–2, STROBE 3–6, HOLD 7–8, DONE 9 (waitrequest low), RECOVER 10–11, IDLE 12.
  - A back-to-back request is accepted at cycle 12.
  - General completion cycle = SETUP + STROBE + HOLD + 1.
- r_n and w_n are never both low; a strobe is never low while cs_n = 1.
- otg_data_oe is never 1 during a read cycle.
- Request deasserted mid-transaction (protocol violation): the bus cycle still runs to DONE and readdata still updates.
- chipselect = 0 with read/write = 1 is ignored.
- readdata holds its last captured value until the next read capture; writes do not alter it.

Test Plan:
- Write: address = 2, writedata = 0x0000_5A3C, defaults → cs_n low cycles 1–8, w_n low cycles 3–6, otg_hpi_address = 2, otg_data_out = 0x5A3C with oe = 1 cycles 1–8, waitrequest low only in cycle 9.
- Read: address = 0, otg_data_in = 0xBEEF during STROBE, changed to 0x1234 at cycle 7 → readdata = 0x0000_BEEF at cycle 9, r_n low cycles 3–6, oe = 0 throughout.
- Back-to-back: write then read held continuously → second cs_n falling edge no earlier than cycle 13 (2 recovery clocks high); both complete correctly.
- Simultaneous read & write: read = write = 1, writedata = 0x0001 → w_n pulses, r_n stays 1, readdata unchanged.
- Reset mid-cycle: reset_n low during STROBE cycle 4 → cs_n, w_n = 1 and oe = 0 asynchronously; after release, IDLE with no residual pulse; a new request completes normally.
- Parameter sweep: SETUP = 1, STROBE = 1, HOLD = 1, RECOVERY = 0 → DONE at cycle 4, next request accepted at cycle 5; strobe width exactly 1 clock.
